// File: rtl/uart_rx_if.sv
// Serial receive bundle: line input plus recovered byte and status strobes.
// The master modport belongs to the receiver; the slave side feeds rx and consumes data.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF line synchronizer, mid-bit sampling FSM,
// byte register with one-cycle valid / frame_err strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input logic      clk,
    input logic      n_rst,
    uart_rx_if.master bus
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state;
    state_t nxt;

    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;

    logic half_tick;
    logic bit_tick;
    logic busy_c;
    logic cnt_clr;
    logic shift_en;
    logic load;
    logic ferr;

    assign half_tick = (bit_cnt == HALF_LAST);
    assign bit_tick  = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) nxt = START;
            end
            // A start bit that is gone by mid-bit was a glitch
            START: begin
                if (half_tick) nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick && idx == IDX_LAST) nxt = STOP;
            end
            STOP: begin
                if (bit_tick) nxt = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = (state != IDLE);
        cnt_clr  = 1'b1;
        shift_en = 1'b0;
        load     = 1'b0;
        ferr     = 1'b0;
        unique case (state)
            START: begin
                cnt_clr = half_tick;
            end
            DATA: begin
                cnt_clr  = bit_tick;
                shift_en = bit_tick;
            end
            STOP: begin
                cnt_clr = bit_tick;
                load    = bit_tick && rx_s;
                ferr    = bit_tick && !rx_s;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // LSB arrives first, so each sample enters at the top and drifts down
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx   <= '0;
            shreg <= '0;
        end else if (state == IDLE || state == START) begin
            idx <= '0;
        end else if (shift_en) begin
            idx   <= idx + IW'(1);
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= load;
            ferr_q  <= ferr;
            if (load) data_q <= shreg;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at 16 and 4 clocks per bit,
// checked against frame-level timing and data expectations.
module tb_uart_rx;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_if #(.DATA_BITS(8)) bus2 ();

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1.master)
    );

    uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut2 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus2.master)
    );

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int overlap = 0;

    int         v1c[$];
    logic [7:0] v1d[$];
    int         e1c[$];
    int         v2c[$];
    logic [7:0] v2d[$];
    int         e2c[$];

    int         x1c[$];
    logic [7:0] x1d[$];
    int         xe1c[$];
    int         x2c[$];
    logic [7:0] x2d[$];
    int         xe2c[$];

    logic [7:0] last1 = 8'h00;
    logic [7:0] last2 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus1.valid) begin
            v1c.push_back(cyc);
            v1d.push_back(bus1.data);
        end
        if (bus1.frame_err) e1c.push_back(cyc);
        if (bus2.valid) begin
            v2c.push_back(cyc);
            v2d.push_back(bus2.data);
        end
        if (bus2.frame_err) e2c.push_back(cyc);
        if ((bus1.valid && bus1.frame_err) || (bus2.valid && bus2.frame_err))
            overlap++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting at the next edge; the model predicts the
    // strobe at start + 2 sync edges + half a bit + 9 full bits.
    task automatic send(input int which, input logic [7:0] b,
                        input logic stopb, input logic expect_out);
        int cpb;
        int t0;
        int t_out;
        logic [9:0] fr;
        cpb   = (which == 1) ? 16 : 4;
        fr    = {stopb, b, 1'b0};
        t0    = cyc + 1;
        t_out = t0 + 2 + cpb / 2 + 9 * cpb;
        if (expect_out) begin
            if (which == 1) begin
                if (stopb) begin
                    x1c.push_back(t_out);
                    x1d.push_back(b);
                    last1 = b;
                end else begin
                    xe1c.push_back(t_out);
                end
            end else begin
                if (stopb) begin
                    x2c.push_back(t_out);
                    x2d.push_back(b);
                    last2 = b;
                end else begin
                    xe2c.push_back(t_out);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (which == 1) bus1.rx = fr[i];
            else bus2.rx = fr[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic verify(input int which);
        int         oc[$];
        logic [7:0] od[$];
        int         oe[$];
        int         xc[$];
        logic [7:0] xd[$];
        int         xe[$];
        if (which == 1) begin
            oc = v1c; od = v1d; oe = e1c;
            xc = x1c; xd = x1d; xe = xe1c;
            v1c.delete(); v1d.delete(); e1c.delete();
            x1c.delete(); x1d.delete(); xe1c.delete();
        end else begin
            oc = v2c; od = v2d; oe = e2c;
            xc = x2c; xd = x2d; xe = xe2c;
            v2c.delete(); v2d.delete(); e2c.delete();
            x2c.delete(); x2d.delete(); xe2c.delete();
        end
        check("valid_count", oc.size(), xc.size());
        for (int i = 0; i < oc.size() && i < xc.size(); i++) begin
            check("valid_cycle", oc[i], xc[i]);
            check("valid_data", int'(od[i]), int'(xd[i]));
        end
        check("ferr_count", oe.size(), xe.size());
        for (int i = 0; i < oe.size() && i < xe.size(); i++)
            check("ferr_cycle", oe[i], xe[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int t0;
        int gap;

        bus1.rx = 1'b1;
        bus2.rx = 1'b1;
        n_rst   = 1'b0;
        idle(3);
        check("rst_data", int'(bus1.data), 0);
        check("rst_valid", int'(bus1.valid), 0);
        check("rst_ferr", int'(bus1.frame_err), 0);
        check("rst_busy", int'(bus1.busy), 0);
        check("rst_busy2", int'(bus2.busy), 0);
        n_rst = 1'b1;
        idle(4);

        send(1, 8'hA5, 1'b1, 1'b1);
        idle(4);
        verify(1);
        check("a5_data", int'(bus1.data), int'(last1));

        send(1, 8'h00, 1'b1, 1'b1);
        send(1, 8'hFF, 1'b1, 1'b1);
        idle(4);
        check("b2b_count", v1c.size(), 2);
        if (v1c.size() == 2) check("b2b_gap", v1c[1] - v1c[0], 160);
        verify(1);
        check("b2b_data", int'(bus1.data), 8'hFF);

        for (int k = 0; k < 6; k++) begin
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 5));
            idle(gap);
            send(1, b, 1'b1, 1'b1);
        end
        idle(4);
        verify(1);
        check("rand_data", int'(bus1.data), int'(last1));

        t0 = cyc + 1;
        bus1.rx = 1'b0;
        idle(4);
        bus1.rx = 1'b1;
        idle(2);
        check("glitch_busy_hi", int'(bus1.busy), 1);
        idle(9);
        check("glitch_busy_lo", int'(bus1.busy), 0);
        check("glitch_t0", cyc - t0, 14);
        verify(1);

        send(1, 8'h11, 1'b1, 1'b1);
        send(1, 8'h3C, 1'b0, 1'b1);
        idle(40);
        check("break_busy", int'(bus1.busy), 1);
        verify(1);
        check("ferr_data_hold", int'(bus1.data), 8'h11);
        bus1.rx = 1'b1;
        idle(4);
        check("break_idle", int'(bus1.busy), 0);
        send(1, 8'h7E, 1'b1, 1'b1);
        idle(4);
        verify(1);
        check("after_break", int'(bus1.data), 8'h7E);

        fork
            send(1, 8'hC3, 1'b1, 1'b0);
            begin
                repeat (88) @(posedge clk);
                #1;
                check("mid_busy", int'(bus1.busy), 1);
                #2;
                n_rst = 1'b0;
                #1;
                check("mid_rst_data", int'(bus1.data), 0);
                check("mid_rst_valid", int'(bus1.valid), 0);
                check("mid_rst_ferr", int'(bus1.frame_err), 0);
                check("mid_rst_busy", int'(bus1.busy), 0);
            end
        join
        last1 = 8'h00;
        n_rst = 1'b1;
        idle(4);
        verify(1);
        send(1, 8'h5A, 1'b1, 1'b1);
        idle(4);
        verify(1);
        check("post_rst_data", int'(bus1.data), 8'h5A);

        send(2, 8'h81, 1'b1, 1'b1);
        idle(4);
        verify(2);
        check("fast_data", int'(bus2.data), 8'h81);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            idle(int'($urandom_range(0, 3)));
            send(2, b, 1'b1, 1'b1);
        end
        idle(4);
        verify(2);
        check("fast_rand", int'(bus2.data), int'(last2));

        check("never_both", overlap, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
